sha256_stream_core: RTL and testbench

Multi-block SHA-224/SHA-256 compression engine with valid/ready streaming on both sides and a build-time rounds-per-cycle parameter. It accepts pre-padded 512-bit message blocks, chains the intermediate hash across the blocks of one message, and emits one digest per message. It sits between the message padder/DMA front end and the result FIFO in the hashing datapath. Relative to the fixed pipelined transform it adds:
- iterative operation with a selectable unroll factor;
- message chaining;
- SHA-224 mode;
- output back-pressure.

---
 rtl/sha256_pkg.sv | 56 +++++
 rtl/sha256_round.sv | 37 +++
 rtl/sha256_stream_core.sv | 142 ++++++++++++++
 tb/tb_sha256_stream_core.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-224/256 round constants, initial hash values, FIPS 180-4
// bit functions and the engine state encoding.
`default_nettype none

package sha256_pkg;

    localparam int unsigned NUM_ROUNDS = 64;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round plus one step of the rolling
// 16-word message schedule window (W0 in the top word is consumed this round).
`default_nettype none

module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_i,
    input  logic [511:0] win_i,
    input  logic [31:0]  k_i,
    output logic [255:0] state_o,
    output logic [511:0] win_o
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_w0, w_w1, w_w9, w_w14;
    logic [31:0] w_t1, w_t2, w_wnew;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = state_i;

    assign w_w0  = win_i[511:480];
    assign w_w1  = win_i[479:448];
    assign w_w9  = win_i[223:192];
    assign w_w14 = win_i[63:32];

    assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + k_i + w_w0;
    assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

    assign state_o = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

    // W[t+16] becomes the newest window word as W[t] drops off the top.
    assign w_wnew = small_sigma1(w_w14) + w_w9 + small_sigma0(w_w1) + w_w0;
    assign win_o  = {win_i[479:0], w_wnew};

endmodule

`default_nettype wire

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: iterative multi-block SHA-224/256 engine, RPC rounds per
// clock, chaining H across blocks and holding each digest until taken.
`default_nettype none

module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         out_mode
);

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
        $error("sha256_stream_core: RPC must be one of 1, 2, 4, 8, 16");
    end

    state_t         state_q, state_d;
    logic [5:0]     rcnt_q;
    logic [255:0]   h_q;
    logic [255:0]   work_q;
    logic [511:0]   win_q;
    logic           open_q;
    logic           last_q;
    logic           mode_q;
    logic [255:0]   out_digest_q;
    logic           out_mode_q;

    logic           w_accept;
    logic           w_open_new;
    logic [255:0]   w_iv;
    logic [255:0]   w_h_sum;
    logic [255:0]   w_chain_st  [0:RPC];
    logic [511:0]   w_chain_win [0:RPC];

    assign in_ready   = rst_n && (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_OUT);
    assign out_digest = out_digest_q;
    assign out_mode   = out_mode_q;

    assign w_accept   = in_valid && in_ready;
    assign w_open_new = in_first || !open_q;
    assign w_iv       = in_mode ? IV224 : IV256;

    assign w_chain_st[0]  = work_q;
    assign w_chain_win[0] = win_q;

    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [5:0] w_kidx;
        assign w_kidx = rcnt_q + 6'(j);
        sha256_round u_round (
            .state_i (w_chain_st[j]),
            .win_i   (w_chain_win[j]),
            .k_i     (K[w_kidx]),
            .state_o (w_chain_st[j+1]),
            .win_o   (w_chain_win[j+1])
        );
    end

    for (genvar i = 0; i < 8; i++) begin : g_hsum
        assign w_h_sum[32*i +: 32] = h_q[32*i +: 32] + work_q[32*i +: 32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = ST_RUN;
            ST_RUN:  if (rcnt_q == 6'(NUM_ROUNDS - RPC)) state_d = ST_FIN;
            ST_FIN:  state_d = last_q ? ST_OUT : ST_IDLE;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt_q       <= '0;
            h_q          <= '0;
            work_q       <= '0;
            win_q        <= '0;
            open_q       <= 1'b0;
            last_q       <= 1'b0;
            mode_q       <= 1'b0;
            out_digest_q <= '0;
            out_mode_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        win_q  <= in_block;
                        rcnt_q <= '0;
                        last_q <= in_last;
                        if (w_open_new) begin
                            h_q    <= w_iv;
                            work_q <= w_iv;
                            mode_q <= in_mode;
                            open_q <= 1'b1;
                        end else begin
                            work_q <= h_q;
                        end
                    end
                end
                ST_RUN: begin
                    work_q <= w_chain_st[RPC];
                    win_q  <= w_chain_win[RPC];
                    rcnt_q <= rcnt_q + 6'(RPC);
                end
                ST_FIN: begin
                    h_q <= w_h_sum;
                    if (last_q) begin
                        // SHA-224 keeps full 256-bit chaining; only the output is truncated.
                        out_digest_q <= mode_q ? {w_h_sum[255:32], 32'h0} : w_h_sum;
                        out_mode_q   <= mode_q;
                        open_q       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: drives an RPC=1 and an RPC=16 engine with known vectors
// and random messages, comparing against a behavioural SHA-256 model.
`default_nettype none

module tb_sha256_stream_core;

    localparam int RPCV [2] = '{1, 16};

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC256  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC224  = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] TWO256  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [255:0] TB_IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] TB_IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   in_valid, in_first, in_last, in_mode, out_ready;
    logic [1:0]   in_ready, out_valid, out_mode;
    logic [511:0] in_block   [2];
    logic [255:0] out_digest [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_stream_core #(.RPC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_block(in_block[0]),
        .in_first(in_first[0]), .in_last(in_last[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_digest(out_digest[0]), .out_mode(out_mode[0])
    );

    sha256_stream_core #(.RPC(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_block(in_block[1]),
        .in_first(in_first[1]), .in_last(in_last[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_digest(out_digest[1]), .out_mode(out_mode[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_block(input int u, input logic [511:0] blk, input logic f,
                              input logic l, input logic m);
        int n = 0;
        @(negedge clk);
        while (in_ready[u] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (in_ready[u] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout unit %0d in_ready=%b required 1", u, in_ready[u]);
        end
        in_block[u] = blk;
        in_first[u] = f;
        in_last[u]  = l;
        in_mode[u]  = m;
        in_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        // Scramble sideband after the accepting edge; the engine must ignore it.
        in_block[u] = {16{$urandom()}};
        in_first[u] = 1'($urandom());
        in_last[u]  = 1'($urandom());
        in_mode[u]  = 1'($urandom());
    endtask

    task automatic collect(input int u, input int stall, output logic [255:0] d, output logic m);
        int n = 0;
        while (out_valid[u] !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_valid[u] !== 1'b1) begin
            errors++;
            $display("FAIL collect_timeout unit %0d out_valid=%b required 1", u, out_valid[u]);
            d = '0;
            m = 1'b0;
            return;
        end
        d = out_digest[u];
        m = out_mode[u];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[u] !== 1'b1 || out_digest[u] !== d || out_mode[u] !== m || in_ready[u] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold unit %0d valid=%b ready=%b digest=%h required valid=1 ready=0 digest=%h",
                         u, out_valid[u], in_ready[u], out_digest[u], d);
            end
        end
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b00 || out_valid !== 2'b00 || out_mode !== 2'b00 ||
            out_digest[0] !== '0 || out_digest[1] !== '0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b out_mode=%b required 00 00 00 digests 0",
                     in_ready, out_valid, out_mode);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required 11", in_ready);
        end
    endtask

    task automatic test_abc_latency(input int u);
        int lat = 64 / RPCV[u] + 1;
        logic [255:0] d;
        logic m;
        send_block(u, ABC_BLK, 1'b1, 1'b1, 1'b0);
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[u] !== (e == lat)) begin
                errors++;
                $display("FAIL abc_latency unit %0d edge %0d out_valid=%b required %b", u, e, out_valid[u], e == lat);
            end
        end
        collect(u, 0, d, m);
        checks++;
        if (d !== ABC256 || m !== 1'b0) begin
            errors++;
            $display("FAIL abc256 unit %0d digest=%h mode=%b required %h 0", u, d, m, ABC256);
        end
        checks++;
        if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake unit %0d in_ready=%b out_valid=%b required 1 0", u, in_ready[u], out_valid[u]);
        end
    endtask

    task automatic test_abc224(input int u);
        logic [255:0] d;
        logic m;
        send_block(u, ABC_BLK, 1'b1, 1'b1, 1'b1);
        collect(u, 0, d, m);
        checks++;
        if (d !== ABC224 || m !== 1'b1) begin
            errors++;
            $display("FAIL abc224 unit %0d digest=%h mode=%b required %h 1", u, d, m, ABC224);
        end
    endtask

    task automatic test_two_block(input int u);
        int lat = 64 / RPCV[u] + 1;
        logic [255:0] d;
        logic m;
        send_block(u, TWO_B1, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[u] !== 1'b0 || in_ready[u] !== (e == lat)) begin
                errors++;
                $display("FAIL two_block_mid unit %0d edge %0d out_valid=%b in_ready=%b required 0 %b",
                         u, e, out_valid[u], in_ready[u], e == lat);
            end
        end
        // Mode on a continuation block must be ignored.
        send_block(u, TWO_B2, 1'b0, 1'b1, 1'b1);
        collect(u, 0, d, m);
        checks++;
        if (d !== TWO256 || m !== 1'b0) begin
            errors++;
            $display("FAIL two_block unit %0d digest=%h mode=%b required %h 0", u, d, m, TWO256);
        end
    endtask

    task automatic test_back_to_back(input int u);
        int lat = 64 / RPCV[u] + 1;
        logic [255:0] d0, d1, d2;
        logic m;
        send_block(u, ABC_BLK, 1'b1, 1'b1, 1'b0);
        in_valid[u] = 1'b1;
        in_block[u] = ~ABC_BLK;
        in_first[u] = 1'b1;
        in_last[u]  = 1'b1;
        collect(u, 10, d0, m);
        in_valid[u] = 1'b0;
        for (int e = 0; e < lat + 2; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[u] !== 1'b0) begin
                errors++;
                $display("FAIL no_second_digest unit %0d out_valid=%b required 0", u, out_valid[u]);
            end
        end
        send_block(u, ABC_BLK, 1'b1, 1'b1, 1'b0);
        collect(u, 0, d1, m);
        send_block(u, ABC_BLK, 1'b1, 1'b1, 1'b0);
        collect(u, 0, d2, m);
        checks++;
        if (d0 !== ABC256 || d1 !== ABC256 || d2 !== ABC256) begin
            errors++;
            $display("FAIL back_to_back unit %0d digests=%h %h %h required %h", u, d0, d1, d2, ABC256);
        end
    endtask

    task automatic test_abandon(input int u);
        int lat = 64 / RPCV[u] + 1;
        logic [255:0] d;
        logic m;
        send_block(u, TWO_B1, 1'b1, 1'b0, 1'b0);
        for (int e = 0; e < lat; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[u] !== 1'b0) begin
                errors++;
                $display("FAIL abandon_no_out unit %0d out_valid=%b required 0", u, out_valid[u]);
            end
        end
        send_block(u, ABC_BLK, 1'b1, 1'b1, 1'b0);
        collect(u, 0, d, m);
        checks++;
        if (d !== ABC256 || m !== 1'b0) begin
            errors++;
            $display("FAIL abandon unit %0d digest=%h required %h", u, d, ABC256);
        end
    endtask

    task automatic test_midrun_reset(input int u);
        logic [255:0] d;
        logic m;
        send_block(u, TWO_B1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready[u] !== 1'b0 || out_valid[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold unit %0d in_ready=%b out_valid=%b required 0 0", u, in_ready[u], out_valid[u]);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[u] !== 1'b0 || out_digest[u] !== '0 || out_mode[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs unit %0d valid=%b digest=%h mode=%b required 0 0 0",
                     u, out_valid[u], out_digest[u], out_mode[u]);
        end
        rst_n = 1'b1;
        // No message is open after reset, so first=0 must still start from the IV.
        send_block(u, ABC_BLK, 1'b0, 1'b1, 1'b0);
        collect(u, 0, d, m);
        checks++;
        if (d !== ABC256 || m !== 1'b0) begin
            errors++;
            $display("FAIL post_reset unit %0d digest=%h required %h", u, d, ABC256);
        end
    endtask

    task automatic test_random(input int u, input int nmsg);
        logic [255:0] h, exp_d, d;
        logic [511:0] blk;
        logic mode, m;
        int nb;
        for (int k = 0; k < nmsg; k++) begin
            nb   = int'($urandom_range(1, 3));
            mode = 1'($urandom());
            h    = mode ? TB_IV224 : TB_IV256;
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom();
                h = ref_compress(h, blk);
                send_block(u, blk, b == 0, b == nb - 1, (b == 0) ? mode : 1'($urandom()));
            end
            exp_d = mode ? {h[255:32], 32'h0} : h;
            collect(u, int'($urandom_range(0, 3)), d, m);
            checks++;
            if (d !== exp_d || m !== mode) begin
                errors++;
                $display("FAIL random unit %0d msg %0d blocks %0d digest=%h mode=%b required %h %b",
                         u, k, nb, d, m, exp_d, mode);
            end
        end
    endtask

    initial begin
        in_valid  = '0;
        in_first  = '0;
        in_last   = '0;
        in_mode   = '0;
        out_ready = '0;
        in_block[0] = '0;
        in_block[1] = '0;
        test_reset();
        for (int u = 0; u < 2; u++) begin
            test_abc_latency(u);
            test_abc224(u);
            test_two_block(u);
            test_back_to_back(u);
            test_abandon(u);
            test_midrun_reset(u);
            test_random(u, 6);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
